// File: rtl/weight_config_loader.sv
// Stream-to-weight-memory write loader: parses a framed header, then forwards
// sign-extended weights with their target layer/neuron to the weight memories.
module weight_config_loader #(
    parameter int data_bits   = 16,
    parameter int num_layers  = 4,
    parameter int max_neurons = 64,
    parameter int max_weights = 784
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        abort,
    output logic        weight_valid,
    output logic [31:0] weight_value,
    output logic [31:0] config_layer_no,
    output logic [31:0] config_neuron_no,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [15:0] MAX_W = 16'(max_weights);
    localparam logic [8:0]  NUM_L = 9'(num_layers);
    localparam logic [8:0]  MAX_N = 9'(max_neurons);

    state_t      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic        weight_valid_q, weight_valid_d;
    logic [31:0] weight_value_q, weight_value_d;
    logic [31:0] layer_q, layer_d;
    logic [31:0] neuron_q, neuron_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [15:0]                hdr_count;
    logic [7:0]                 hdr_layer;
    logic [7:0]                 hdr_neuron;
    logic                       hdr_legal;
    logic signed [data_bits-1:0] weight_raw;

    assign hdr_count  = s_data[31:16];
    assign hdr_layer  = s_data[15:8];
    assign hdr_neuron = s_data[7:0];
    assign hdr_legal  = (hdr_count != 16'd0) && (hdr_count <= MAX_W) &&
                        ({1'b0, hdr_layer} < NUM_L) && ({1'b0, hdr_neuron} < MAX_N);
    assign weight_raw = s_data[data_bits-1:0];

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        weight_value_d = weight_value_q;
        layer_d        = layer_q;
        neuron_d       = neuron_q;
        weight_valid_d = 1'b0;
        done_d         = 1'b0;
        error_d        = 1'b0;
        case (state_q)
            IDLE: begin
                // abort is deliberately ignored here, even alongside a header
                if (s_valid) begin
                    if (hdr_legal) begin
                        layer_d     = 32'(hdr_layer);
                        neuron_d    = 32'(hdr_neuron);
                        remaining_d = hdr_count;
                        state_d     = LOAD;
                    end else begin
                        error_d = 1'b1;
                        if (hdr_count != 16'd0) begin
                            remaining_d = hdr_count;
                            state_d     = DRAIN;
                        end
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (s_valid) begin
                    weight_value_d = 32'(weight_raw);
                    weight_valid_d = 1'b1;
                    remaining_d    = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (s_valid) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            weight_valid_q <= 1'b0;
            weight_value_q <= '0;
            layer_q        <= '0;
            neuron_q       <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            weight_valid_q <= weight_valid_d;
            weight_value_q <= weight_value_d;
            layer_q        <= layer_d;
            neuron_q       <= neuron_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    // The loader never backpressures; every offered word is consumed.
    assign s_ready          = 1'b1;
    assign weight_valid     = weight_valid_q;
    assign weight_value     = weight_value_q;
    assign config_layer_no  = layer_q;
    assign config_neuron_no = neuron_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_weight_config_loader.sv
// Bench for weight_config_loader: vector table plus hand sequences, with
// per-cycle expectations queued at drive time and checked after the edge.
module tb_weight_config_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic        weight_valid;
    logic [31:0] weight_value;
    logic [31:0] config_layer_no;
    logic [31:0] config_neuron_no;
    logic        busy;
    logic        done;
    logic        error;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    weight_config_loader #(
        .data_bits  (16),
        .num_layers (4),
        .max_neurons(64),
        .max_weights(784)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .abort           (abort),
        .weight_valid    (weight_valid),
        .weight_value    (weight_value),
        .config_layer_no (config_layer_no),
        .config_neuron_no(config_neuron_no),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ab;
        logic        wv;
        logic [31:0] wval;
        logic        dn;
        logic        err;
        logic        bsy;
        logic [31:0] lay;
        logic [31:0] neu;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[30];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic ab,
                                input logic wv, input logic [31:0] wval, input logic dn,
                                input logic err, input logic bsy,
                                input logic [31:0] lay, input logic [31:0] neu);
        vec_t t;
        t.v = v; t.d = d; t.ab = ab; t.wv = wv; t.wval = wval;
        t.dn = dn; t.err = err; t.bsy = bsy; t.lay = lay; t.neu = neu;
        return t;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expectation is queued as the stimulus is driven and retired after the edge.
    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        sb_q.push_back(t);
        s_valid = t.v;
        s_data  = t.d;
        abort   = t.ab;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".weight_valid"}, 32'(weight_valid), 32'(e.wv));
        if (e.wv) chk({tag, ".weight_value"}, weight_value, e.wval);
        chk({tag, ".done"}, 32'(done), 32'(e.dn));
        chk({tag, ".error"}, 32'(error), 32'(e.err));
        chk({tag, ".busy"}, 32'(busy), 32'(e.bsy));
        chk({tag, ".layer"}, config_layer_no, e.lay);
        chk({tag, ".neuron"}, config_neuron_no, e.neu);
        chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".weight_valid"}, 32'(weight_valid), 32'd0);
        chk({tag, ".weight_value"}, weight_value, 32'd0);
        chk({tag, ".layer"}, config_layer_no, 32'd0);
        chk({tag, ".neuron"}, config_neuron_no, 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".error"}, 32'(error), 32'd0);
        chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        v  data          ab wv wval          dn er by lay neu
        tbl[0]  = mk(1, 32'h0003_0102, 0, 0, 32'h0,         0, 0, 1, 1, 2);
        tbl[1]  = mk(1, 32'h0000_FFFE, 0, 1, 32'hFFFF_FFFE, 0, 0, 1, 1, 2);
        tbl[2]  = mk(1, 32'h0000_0005, 0, 1, 32'h0000_0005, 0, 0, 1, 1, 2);
        tbl[3]  = mk(1, 32'h0000_8000, 0, 1, 32'hFFFF_8000, 1, 0, 0, 1, 2);
        tbl[4]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 1, 2);
        tbl[5]  = mk(1, 32'h0002_0700, 0, 0, 32'h0,         0, 1, 1, 1, 2);
        tbl[6]  = mk(1, 32'h0000_1234, 0, 0, 32'h0,         0, 0, 1, 1, 2);
        tbl[7]  = mk(1, 32'h0000_5678, 0, 0, 32'h0,         0, 0, 0, 1, 2);
        tbl[8]  = mk(1, 32'h0000_0000, 0, 0, 32'h0,         0, 1, 0, 1, 2);
        tbl[9]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 1, 2);
        tbl[10] = mk(1, 32'h0005_0304, 0, 0, 32'h0,         0, 0, 1, 3, 4);
        tbl[11] = mk(1, 32'h0000_0011, 0, 1, 32'h0000_0011, 0, 0, 1, 3, 4);
        tbl[12] = mk(1, 32'h0000_0022, 0, 1, 32'h0000_0022, 0, 0, 1, 3, 4);
        tbl[13] = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 0, 3, 4);
        tbl[14] = mk(1, 32'h0001_0001, 1, 0, 32'h0,         0, 0, 1, 0, 1);
        tbl[15] = mk(1, 32'h0000_ABCD, 0, 1, 32'hFFFF_ABCD, 1, 0, 0, 0, 1);
        tbl[16] = mk(1, 32'h0002_0203, 0, 0, 32'h0,         0, 0, 1, 2, 3);
        tbl[17] = mk(1, 32'h0000_0001, 1, 0, 32'h0,         0, 1, 0, 2, 3);
        tbl[18] = mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 0, 2, 3);
        tbl[19] = mk(1, 32'h0002_0101, 0, 0, 32'h0,         0, 0, 1, 1, 1);
        tbl[20] = mk(1, 32'h0000_0010, 0, 1, 32'h0000_0010, 0, 0, 1, 1, 1);
        tbl[21] = mk(1, 32'h0000_0020, 0, 1, 32'h0000_0020, 1, 0, 0, 1, 1);
        tbl[22] = mk(1, 32'h0001_023F, 0, 0, 32'h0,         0, 0, 1, 2, 63);
        tbl[23] = mk(1, 32'h0000_FFFF, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 2, 63);
        tbl[24] = mk(1, 32'h0001_0040, 0, 0, 32'h0,         0, 1, 1, 2, 63);
        tbl[25] = mk(1, 32'h0000_0000, 0, 0, 32'h0,         0, 0, 0, 2, 63);
        tbl[26] = mk(1, 32'h0311_0000, 0, 0, 32'h0,         0, 1, 1, 2, 63);
        tbl[27] = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 0, 2, 63);
        tbl[28] = mk(1, 32'h0001_0300, 0, 0, 32'h0,         0, 0, 1, 3, 0);
        tbl[29] = mk(1, 32'hABCD_7FFF, 0, 1, 32'h0000_7FFF, 1, 0, 0, 3, 0);

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        abort   = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Count of 4 with 0..3 idle cycles before each weight.
        apply(mk(1, 32'h0004_0201, 0, 0, 32'h0, 0, 0, 1, 2, 1), "gap.hdr");
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < k; g++)
                apply(mk(0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 2, 1), $sformatf("gap%0d.idle%0d", k, g));
            apply(mk(1, 32'(32'h100 + k), 0, 1, 32'(32'h100 + k), (k == 3), 0, (k != 3), 2, 1),
                  $sformatf("gap%0d.word", k));
        end
        apply(mk(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 2, 1), "gap.after");

        // Asynchronous reset in the middle of a frame.
        apply(mk(1, 32'h0003_0102, 0, 0, 32'h0, 0, 0, 1, 1, 2), "arst.hdr");
        apply(mk(1, 32'h0000_0042, 0, 1, 32'h0000_0042, 0, 0, 1, 1, 2), "arst.w0");
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst.mid");
        s_valid = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk(1, 32'h0001_0203, 0, 0, 32'h0, 0, 0, 1, 2, 3), "arst.hdr2");
        apply(mk(1, 32'h0000_7FFF, 0, 1, 32'h0000_7FFF, 1, 0, 0, 2, 3), "arst.w");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 2, 3), "arst.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
